// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter with a one-entry registered write stage and pending mask.
// Define RF_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module rf_write_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [5*NUM_REQ-1:0]  req_addr,
    input  logic [32*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic                  flush,
    output logic                  we3,
    output logic [4:0]            a3,
    output logic [31:0]           wd3,
    output logic [1:0]            grant_id,
    output logic [31:0]           pending_mask
);

    logic [1:0]  win_p0;
    logic        found_p0;
    logic        xfer_p0;
    logic [4:0]  win_addr_p0;
    logic [31:0] win_data_p0;

    logic        vld_p1;
    logic [4:0]  addr_p1;
    logic [31:0] data_p1;
    logic [1:0]  id_p1;

    // Stage p0: grant selection (combinational)
`ifdef RF_ARB_FIXED_PRIO_EN
    always_comb begin
        win_p0   = '0;
        found_p0 = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                win_p0   = 2'(i);
                found_p0 = 1'b1;
            end
        end
    end
`else
    logic [1:0] last_grant;
    logic [2:0] idx_p0;

    // Scan the search order backwards so the first valid requester in order wins.
    always_comb begin
        win_p0   = '0;
        found_p0 = 1'b0;
        idx_p0   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx_p0 = 3'(last_grant) + 3'(k);
            if (idx_p0 >= 3'(NUM_REQ))
                idx_p0 = idx_p0 - 3'(NUM_REQ);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (idx_p0 == 3'(i) && req_valid[i]) begin
                    win_p0   = 2'(i);
                    found_p0 = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant <= 2'(NUM_REQ - 1);
        else if (xfer_p0)
            last_grant <= win_p0;
    end
`endif

    assign xfer_p0 = found_p0 & ~flush & rst_n;

    always_comb begin
        req_ready   = '0;
        win_addr_p0 = '0;
        win_data_p0 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_p0 == 2'(i)) begin
                req_ready[i] = xfer_p0;
                win_addr_p0  = req_addr[5*i +: 5];
                win_data_p0  = req_data[32*i +: 32];
            end
        end
    end

    // Stage p1: write stage; x0 transfers complete the handshake but never load it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
            id_p1   <= '0;
        end else begin
            vld_p1 <= xfer_p0 && (win_addr_p0 != 5'd0);
            if (xfer_p0 && (win_addr_p0 != 5'd0)) begin
                addr_p1 <= win_addr_p0;
                data_p1 <= win_data_p0;
                id_p1   <= win_p0;
            end
        end
    end

    assign we3          = vld_p1 & ~flush;
    assign a3           = addr_p1;
    assign wd3          = data_p1;
    assign grant_id     = id_p1;
    assign pending_mask = vld_p1 ? (32'd1 << addr_p1) : 32'd0;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed cases plus randomized traffic against a behavioural model.
module tb_rf_write_arbiter;
    localparam int N = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [5*N-1:0]  req_addr;
    logic [32*N-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic          flush;
    logic          we3;
    logic [4:0]    a3;
    logic [31:0]   wd3;
    logic [1:0]    grant_id;
    logic [31:0]   pending_mask;

    always #5 clk = ~clk;

    rf_write_arbiter #(.NUM_REQ(N)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .flush(flush), .we3(we3),
        .a3(a3), .wd3(wd3), .grant_id(grant_id), .pending_mask(pending_mask)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: staged write, last grant, and two register files (model vs. what the DUT wrote)
    int          m_last;
    bit          m_vld;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [1:0]  m_id;
    logic [N-1:0] m_r;
    logic [31:0] m_rf [32];
    logic [31:0] d_rf [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r = '0;
        if (!rst_n || flush) return r;
`ifdef RF_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++)
            if (req_valid[i]) begin r[i] = 1'b1; return r; end
`else
        for (int k = 1; k <= N; k++) begin
            int idx = (m_last + k) % N;
            if (req_valid[idx]) begin r[idx] = 1'b1; return r; end
        end
`endif
        return r;
    endfunction

    task automatic settle();
        #1;
        if (!rst_n) begin
            m_vld = 0; m_last = N - 1; m_addr = '0; m_data = '0; m_id = '0;
        end
        m_r = model_ready();
        chk("req_ready", 32'(req_ready), 32'(m_r));
        chk("we3", 32'(we3), 32'(m_vld && !flush));
        chk("pending_mask", pending_mask, m_vld ? (32'd1 << m_addr) : 32'd0);
        if (m_vld || !rst_n) begin
            chk("a3", 32'(a3), 32'(m_addr));
            chk("wd3", wd3, m_data);
            chk("grant_id", 32'(grant_id), 32'(m_id));
        end
        if (m_vld && !flush && rst_n) m_rf[m_addr] = m_data;
        if (we3 === 1'b1) d_rf[a3] = wd3;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            m_vld = 0;
            for (int i = 0; i < N; i++) begin
                if (m_r[i]) begin
                    m_last = i;
                    if (req_addr[5*i +: 5] != 5'd0) begin
                        m_vld  = 1;
                        m_addr = req_addr[5*i +: 5];
                        m_data = req_data[32*i +: 32];
                        m_id   = 2'(i);
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    logic [N-1:0] exp_fair [6];

    initial begin
        for (int r = 0; r < 32; r++) begin m_rf[r] = '0; d_rf[r] = '0; end
        m_vld = 0; m_last = N - 1; m_addr = '0; m_data = '0; m_id = '0; m_r = '0;
`ifdef RF_ARB_FIXED_PRIO_EN
        exp_fair = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`else
        exp_fair = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`endif

        // Reset with everyone requesting
        rst_n = 1'b0; flush = 1'b0; req_valid = '1;
        req_addr = {5'd3, 5'd2, 5'd1};
        req_data = {32'h0000_000C, 32'h0000_000B, 32'h0000_000A};
        repeat (2) @(negedge clk);
        settle();
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_we3", 32'(we3), 32'd0);
        chk("rst_pending", pending_mask, 32'd0);
        tick();
        rst_n = 1'b1;

        // Fairness: all valid for six cycles
        for (int c = 0; c < 6; c++) begin
            settle();
            chk("fair_grant", 32'(req_ready), 32'(exp_fair[c]));
            tick();
        end
        req_valid = '0;
        settle(); tick();

        // Single write x5 = DEADBEEF from requester 1
        req_valid = 3'b010; req_addr[9:5] = 5'd5; req_data[63:32] = 32'hDEAD_BEEF;
        settle();
        chk("single_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        settle();
        chk("single_we3", 32'(we3), 32'd1);
        chk("single_a3", 32'(a3), 32'd5);
        chk("single_wd3", wd3, 32'hDEAD_BEEF);
        chk("single_id", 32'(grant_id), 32'd1);
        chk("single_pend", pending_mask, 32'h0000_0020);
        tick();
        settle();
        chk("single_we3_off", 32'(we3), 32'd0);
        chk("single_pend_off", pending_mask, 32'd0);
        tick();

        // x0 write is accepted and dropped; requester 1 follows
        req_valid = 3'b011; req_addr[4:0] = 5'd0; req_data[31:0] = 32'h0000_1234;
        req_addr[9:5] = 5'd4; req_data[63:32] = 32'h0000_0044;
        settle();
        chk("x0_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 3'b010;
        settle();
        chk("x0_we3", 32'(we3), 32'd0);
        chk("x0_pend", pending_mask, 32'd0);
        chk("x0_next_grant", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        settle(); tick();

        // Flush kills the staged write to x7 and blocks grants
        req_valid = 3'b100; req_addr[14:10] = 5'd7; req_data[95:64] = 32'h0000_0077;
        settle();
        chk("flush_pre_ready", 32'(req_ready), 32'h4);
        tick();
        flush = 1'b1; req_addr[14:10] = 5'd8; req_data[95:64] = 32'h0000_0088;
        settle();
        chk("flush_we3", 32'(we3), 32'd0);
        chk("flush_ready", 32'(req_ready), 32'd0);
        tick();
        flush = 1'b0;
        settle();
        chk("flush_stage_empty", pending_mask, 32'd0);
        chk("flush_we3_after", 32'(we3), 32'd0);
        tick();
        req_valid = '0;
        settle();
        chk("flush_x7_kept", d_rf[7], 32'd0);
        tick();

        // Collision on x9: A from requester 0 then B from requester 2
        req_valid = 3'b101;
        req_addr[4:0] = 5'd9;   req_data[31:0] = 32'h0000_000A;
        req_addr[14:10] = 5'd9; req_data[95:64] = 32'h0000_000B;
        settle();
        chk("coll_ready0", 32'(req_ready), 32'h1);
        tick();
        req_valid = 3'b100;
        settle();
        chk("coll_ready2", 32'(req_ready), 32'h4);
        chk("coll_we3_a", 32'(we3), 32'd1);
        chk("coll_a3_a", 32'(a3), 32'd9);
        chk("coll_wd3_a", wd3, 32'h0000_000A);
        tick();
        req_valid = '0;
        settle();
        chk("coll_we3_b", 32'(we3), 32'd1);
        chk("coll_a3_b", 32'(a3), 32'd9);
        chk("coll_wd3_b", wd3, 32'h0000_000B);
        tick();
        settle();
        chk("coll_we3_off", 32'(we3), 32'd0);
        chk("coll_x9_final", d_rf[9], 32'h0000_000B);
        tick();

        // Randomized traffic with occasional flush and mid-run reset
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || m_r[i]) begin
                    if ($urandom_range(0, 9) < 6) begin
                        req_valid[i] = 1'b1;
                        req_addr[5*i +: 5] = 5'($urandom_range(0, 7));
                        req_data[32*i +: 32] = $urandom;
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            flush = ($urandom_range(0, 9) == 0);
            rst_n = !($urandom_range(0, 199) == 0);
            settle();
            tick();
        end

        rst_n = 1'b1; flush = 1'b0; req_valid = '0;
        settle(); tick();
        settle(); tick();
        for (int r = 0; r < 32; r++)
            chk("rf_final", d_rf[r], m_rf[r]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the register file's single write port (we3/a3/wd3) among several writeback requesters, e.g. ALU writeback, load writeback and a multicycle mul/div unit. Arbitrates round-robin with a valid/ready handshake per requester, then registers the winning write into a one-entry stage that drives the register file. Publishes a pending mask so hazard logic knows which destinations are in flight. It sits between the writeback sources and the register file write port.

## Interface
- NUM_REQ, default 3: number of requesters; legal range 2..4.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  requester i has a write pending.
- req_addr  in  5*NUM_REQ  destination register; slice [5i+4:5i] belongs to requester i.
- req_data  in  32*NUM_REQ  write data; slice [32i+31:32i] belongs to requester i.
- req_ready  out  NUM_REQ  one-hot grant, combinational; transfer when valid&ready.
- flush  in  1  synchronous kill of the staged write and of new grants.
- we3  out  1  register file write enable, registered.
- a3  out  5  register file write address, registered.
- wd3  out  32  register file write data, registered.
- grant_id  out  2  index of the requester whose write is currently staged.
- pending_mask  out  32  bit r is set while a write to register r is staged.

## Operation
- Grant logic:
  - req_ready is at most one-hot and is 0 for requesters with req_valid=0.
  - Round-robin search starts at (last_grant+1) mod NUM_REQ and picks the first valid requester.
  - last_grant updates only on a completed transfer.
- Stage:
  - On a transfer with req_addr≠0, the stage captures {addr, data, id} and stage_valid=1 at the next edge.
  - With no transfer, stage_valid clears at the next edge. The stage never holds a write for more than one cycle; the register file always accepts.
- x0 writes: accepted (ready=1, handshake completes, pointer advances) but dropped. stage_valid=0, we3 stays 0, no pending bit is set.
- Outputs:
  - we3 = stage_valid & ~flush.
  - a3, wd3 and grant_id show stage contents.
  - pending_mask = one-hot(a3) when stage_valid, else 0.
- flush=1:
  - req_ready forced to 0.
  - we3 forced to 0 in the same cycle.
  - Stage cleared at the next edge.
  - last_grant unchanged.
- Same address from two requesters: served in grant order. The later grant's data is the final register value.
- Requesters must hold valid, addr and data stable until ready. The block does not check this.

## Timing
- Reset values:
  - we3=0, a3=0, wd3=0, grant_id=0, pending_mask=0, all req_ready=0 while rst_n=0.
  - last_grant=NUM_REQ-1, so requester 0 wins first after reset.
- Latency:
  - Handshake in cycle N.
  - we3/a3/wd3 valid in cycle N+1.
  - Register file captures at the end of N+1.
  - The new value is readable in cycle N+2.
- Throughput: one write per cycle, sustained. A requester that is continuously valid is granted at least once every NUM_REQ cycles.
- Reset asserted mid-operation clears the stage immediately. A staged write that has not been captured is lost.
- flush and a transfer in the same cycle: flush wins and no transfer occurs.

## Configuration
- RF_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins. last_grant is not implemented; everything else is identical.
- Not defined: round-robin as described above.

## Test plan
- Reset: hold rst_n=0, drive all req_valid=1 -> req_ready=0, we3=0, pending_mask=0. On release, req_ready=3'b001 first.
- Single write: req 1 writes x5=0xDEADBEEF in cycle N -> cycle N+1: we3=1, a3=5, wd3=0xDEADBEEF, grant_id=1, pending_mask=0x00000020. Cycle N+2: we3=0, pending_mask=0.
- Fairness: all three requesters valid for 6 cycles with distinct addresses -> grants 0,1,2,0,1,2. With RF_ARB_FIXED_PRIO_EN the grants are 0,0,0,0,0,0.
- x0 drop: req 0 writes x0=0x1234 -> req_ready[0]=1 and we3 stays 0 the next cycle. The following grant goes to req 1.
- Flush: staged write to x7 with flush=1 in cycle N+1 -> we3=0 in N+1, req_ready=0 in N+1, stage empty in N+2, x7 unchanged.
- Collision: req 0 writes x9=0xA, req 2 writes x9=0xB in the same cycle -> two consecutive we3 pulses (A then B), final x9=0xB.
